fnd_scan_ctrl: RTL and testbench
================================

# fnd_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode FND on the game-logic board. It takes four packed BCD digits plus decimal-point enables and rotates a one-digit-active, active-low common select across the display. It produces the matching active-low segment pattern for each digit, with dead-time blanking between digits to suppress ghosting. It sits between the score/dice logic and the FND pins, and generates the digit index that the 2-to-4 digit-select decoding consumes.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency in Hz
- `SCAN_HZ`, 1000, per-digit dwell rate in Hz; `DIV = CLK_HZ/SCAN_HZ` (integer, must be ≥ 2)
- `BLANK_CYC`, 16, dead-time clocks at the start of each digit slot with all commons off; must satisfy `BLANK_CYC < DIV`

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst_n`  in  1  **one clock; reset is synchronous and active-low**
- `bcd_data`  in  16  four BCD digits; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3
- `dp_en`  in  4  per-digit decimal-point enable; bit n belongs to digit n
- `blank`  in  1  high forces all commons off; the scan keeps running
- `fnd_com`  out  4  active-low digit commons; `1110` selects digit 0, `0111` selects digit 3
- `fnd_data`  out  8  active-low segments `{dp,g,f,e,d,c,b,a}`

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. `tick` is asserted when `cnt == DIV-1`.
- Digit index `idx` (2 bits) increments on `tick` and wraps from 3 to 0.
- Shadow register `shadow` captures `bcd_data` and `dp_en` on the `tick` that wraps `idx` from 3 to 0. This keeps each frame coherent. Input changes mid-frame are not shown until the next frame.
- Segment encoding (hex, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Any nibble value from A to F displays a dash, BF.
- If the digit's shadowed `dp_en` bit is set, `fnd_data[7]` is cleared.
- Commons:
  - `fnd_com = 1111` if `blank`, or if `cnt < BLANK_CYC`.
  - Otherwise `fnd_com` is the one-hot-low decode of `idx`.
- `fnd_data` always reflects the current `idx`, even while the commons are off.
- Reset values: `cnt=0`, `idx=0`, `shadow=0`, `fnd_com=1111`, `fnd_data=FF`.
- After reset, digit-0 slots show `0` (C0) from the zeroed shadow until the first 3→0 wrap, which occurs 4·DIV cycles after reset release.
- Synchronous reset asserted mid-slot returns everything to the reset values on the next edge; no partial digit persists.

## Timing
- `fnd_com` and `fnd_data` are registered from the registered `cnt`/`idx`/`shadow` (one cycle of latency). At clock edge k+1, the outputs show the state that held at edge k.
- Slot n occupies DIV clocks. Commons are off for the first BLANK_CYC clocks of the slot and on for the remaining DIV-BLANK_CYC clocks.
- Full refresh period is 4·DIV clocks.
- `blank` rising: `fnd_com = 1111` on the next edge.
- `blank` falling: commons resume on the next edge, following the normal `cnt`/`idx` rule. The scan phase is undisturbed.
- `bcd_data` sampled on the wrap edge first appears in the outputs one edge later, together with `fnd_com = 1111` (dead time for digit 0).

## Configuration
- `FND_LZB_EN` (leading-zero blanking).
  - **Defined:** digits 3, 2 and 1 have their segments forced to FF when that digit and all higher digits in `shadow` are 0. A blanked digit still lights dp if its dp bit is set (`fnd_data = 7F`). Digit 0 is never blanked. Commons are unaffected.
  - **Undefined:** all digits are always decoded, and leading zeros show as C0.

## Test plan
Use `CLK_HZ=1000`, `SCAN_HZ=100` (DIV=10) and `BLANK_CYC=2` unless stated otherwise.
- **Reset:** hold `rst_n=0` for 3 clocks with `bcd_data=1234`. Expect `fnd_com=1111` and `fnd_data=FF` on every edge. After release, digit 0 shows C0 until cycle 40.
- **Scan order and dead time:** `bcd_data=1234`, `dp_en=0`, after the first wrap. Each 10-clock slot shows 2 clocks of `1111`, then 8 clocks of the active common with data:
  - `1110`, 99
  - `1101`, B0
  - `1011`, A4
  - `0111`, F9
- **Frame coherence:** change `bcd_data` from 1234 to 5678 while digit 2 is active. Digits 2 and 3 still show 2 and 1 for the rest of that frame. Next frame shows 8, 7, 6, 5 (80, F8, 82, 92).
- **dp and invalid BCD:** `bcd_data=0x0A09`, `dp_en=0001`. Expect:
  - digit 0: 10 (9 with dp)
  - digit 1: BF
  - digit 2: C0
  - digit 3: C0 (with `FND_LZB_EN` defined: FF)
- **Leading-zero blanking (`FND_LZB_EN`):** `bcd_data=0x0005`, `dp_en=0100`. Expect digit 0 = 92, digit 1 = FF, digit 2 = 7F, digit 3 = FF.
- **Blank:** pulse `blank` for 15 clocks mid-slot. `fnd_com=1111` from the next edge for exactly 15 clocks. Afterwards `idx` and `cnt` continue exactly as if `blank` had never been asserted.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit common-anode FND scan controller with dead-time blanking between digits.
// Optional leading-zero blanking of digits 3..1 is enabled by defining FND_LZB_EN.
module fnd_scan_ctrl #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_data,
  input  logic [3:0]  dp_en,
  input  logic        blank,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntMax   = CW'(DIV - 1);
  localparam logic [CW-1:0] CntBlank = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [19:0]   shadow_q, shadow_d;
  logic [3:0]    com_q, com_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick;
  logic [15:0]   bcd_sh;
  logic [3:0]    dp_sh;
  logic [3:0]    digit;
  logic [7:0]    glyph;
  logic          lz_blank;

  assign tick   = (cnt_q == CntMax);
  assign bcd_sh = shadow_q[15:0];
  assign dp_sh  = shadow_q[19:16];
  assign digit  = bcd_sh[{idx_q, 2'b00} +: 4];

  // Shadow only reloads on the 3->0 wrap so a frame never mixes old and new digits.
  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shadow_d = (tick && (idx_q == 2'd3)) ? {dp_en, bcd_data} : shadow_q;
  end

  always_comb begin
    unique case (digit)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hBF;
    endcase
  end

`ifdef FND_LZB_EN
  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    unique case (idx_q)
      2'd3:    lz_blank = (bcd_sh[15:12] == 4'd0);
      2'd2:    lz_blank = (bcd_sh[15:8] == 8'd0);
      2'd1:    lz_blank = (bcd_sh[15:4] == 12'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    seg_d = lz_blank ? 8'hFF : glyph;
    if (dp_sh[idx_q]) begin
      seg_d[7] = 1'b0;
    end
    com_d = (blank || (cnt_q < CntBlank)) ? 4'hF : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 20'd0;
      com_q    <= 4'hF;
      seg_q    <= 8'hFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      com_q    <= com_d;
      seg_q    <= seg_d;
    end
  end

  assign fnd_com  = com_q;
  assign fnd_data = seg_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: directed and random stimulus checked every clock against a
// time-based reference model (slot and phase derived from edges since reset).
module tb_fnd_scan_ctrl;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned SCAN_HZ   = 100;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned DIV       = CLK_HZ / SCAN_HZ;
  localparam int unsigned FRAME     = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_data = 16'h0;
  logic [3:0]  dp_en = 4'h0;
  logic        blank = 1'b0;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned t = 0;        // edges since the last reset edge
  logic [19:0] sh_m = 20'h0; // frame contents the display should be showing
  logic [7:0]  seg_tab [16];

  always #5 clk = ~clk;

  fnd_scan_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .SCAN_HZ  (SCAN_HZ),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bcd_data(bcd_data),
    .dp_en   (dp_en),
    .blank   (blank),
    .fnd_com (fnd_com),
    .fnd_data(fnd_data)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs visible after the edge that follows state index tt.
  function automatic logic [11:0] model_out(input int unsigned tt, input logic [19:0] sh,
                                            input logic bl);
    int unsigned ph;
    int unsigned d;
    logic [7:0]  seg;
    logic [3:0]  com;
    ph  = tt % DIV;
    d   = (tt / DIV) % 4;
    seg = seg_tab[sh[d*4 +: 4]];
    if (sh[16+d]) seg[7] = 1'b0;
`ifdef FND_LZB_EN
    if (d > 0 && (sh[15:0] >> (4 * d)) == 16'h0) seg = sh[16+d] ? 8'h7F : 8'hFF;
`endif
    com = (bl || ph < BLANK_CYC) ? 4'hF : ~(4'b0001 << d);
    return {com, seg};
  endfunction

  task automatic step(input string tag);
    logic [11:0] e;
    logic [19:0] cand;
    if (!rst_n) e = 12'hFFF;
    else        e = model_out(t, sh_m, blank);
    cand = {dp_en, bcd_data};
    @(posedge clk);
    #1;
    check({tag, "_com"}, {4'h0, fnd_com}, {4'h0, e[11:8]});
    check({tag, "_data"}, fnd_data, e[7:0]);
    if (!rst_n) begin
      t    = 0;
      sh_m = 20'h0;
    end else begin
      t++;
      if (t % FRAME == 0) sh_m = cand;
    end
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

    rst_n    = 1'b0;
    bcd_data = 16'h1234;
    steps("reset", 3);
    rst_n = 1'b1;

    // Digit 0 from zeroed shadow before the first wrap.
    steps("prewrap", 5);
    check("dig0_prewrap_com", {4'h0, fnd_com}, 8'h0E);
    check("dig0_prewrap_data", fnd_data, 8'hC0);
    steps("prewrap", 40);
    check("dig0_frame1_com", {4'h0, fnd_com}, 8'h0E);
    check("dig0_frame1_data", fnd_data, 8'h99);
    steps("scan", 40);

    // Change data while digit 2 is active.
    while (t % FRAME != 25) step("align");
    bcd_data = 16'h5678;
    steps("coherence", 60);

    bcd_data = 16'h0A09;
    dp_en    = 4'b0001;
    steps("dp_invalid", 2 * FRAME);

    bcd_data = 16'h0005;
    dp_en    = 4'b0100;
    steps("lzb", 2 * FRAME);

    while (t % FRAME != 14) step("align");
    blank = 1'b1;
    steps("blank_on", 15);
    blank = 1'b0;
    steps("blank_off", FRAME + 5);

    while (t % DIV != 5) step("align");
    rst_n = 1'b0;
    step("midreset");
    rst_n = 1'b1;
    steps("after_reset", FRAME + 10);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 1) == 0) bcd_data = 16'($urandom);
        else if ($urandom_range(0, 2) == 0) bcd_data = 16'(4'($urandom_range(0, 9)));
        else bcd_data = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      if ($urandom_range(0, 49) == 0) dp_en = 4'($urandom);
      if ($urandom_range(0, 24) == 0) blank = ~blank;
      rst_n = ($urandom_range(0, 299) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
